// File: rtl/bcd_display_counter_if.sv
// Control and display bundle for bcd_display_counter: count/load requests in, digit codes and status out.
interface bcd_display_counter_if #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 8
);
    logic                  en;
    logic                  up_dn;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [8*DIGITS-1:0]   digits;
    logic [BIN_W-1:0]      bin_value;
    logic                  wrap;
    logic                  load_err;

    modport master (
        output en, up_dn, load, load_val,
        input  digits, bin_value, wrap, load_err
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output digits, bin_value, wrap, load_err
    );
endinterface

// File: rtl/bcd_display_counter.sv
// Up/down BCD counter with parallel binary shadow, range-checked BCD load and wrap/load_err pulses.
// Optional macro LEADING_ZERO_BLANK_EN replaces leading zero digits (never digit 0) with BLANK_CODE.
module bcd_display_counter #(
    parameter int DIGITS     = 2,
    parameter int MIN_VAL    = 1,
    parameter int MAX_VAL    = 99,
    parameter int RESET_VAL  = 1,
    parameter int BIN_W      = 8,
    parameter int BLANK_CODE = 88
) (
    input  logic                  clk,
    input  logic                  reset,
    bcd_display_counter_if.slave  bus
);

    function automatic logic [4*DIGITS-1:0] to_bcd(input int value);
        logic [4*DIGITS-1:0] r;
        int                  v;
        r = '0;
        v = value;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    localparam logic [4*DIGITS-1:0] MIN_BCD   = to_bcd(MIN_VAL);
    localparam logic [4*DIGITS-1:0] MAX_BCD   = to_bcd(MAX_VAL);
    localparam logic [4*DIGITS-1:0] RESET_BCD = to_bcd(RESET_VAL);
    localparam logic [BIN_W-1:0]    MIN_BIN   = BIN_W'(MIN_VAL);
    localparam logic [BIN_W-1:0]    MAX_BIN   = BIN_W'(MAX_VAL);
    localparam logic [BIN_W-1:0]    RESET_BIN = BIN_W'(RESET_VAL);

    logic [4*DIGITS-1:0] count_reg, count_next;
    logic [BIN_W-1:0]    bin_reg, bin_next;
    logic                wrap_reg, wrap_next;
    logic                load_err_reg, load_err_next;

    logic [4*DIGITS-1:0] inc_bcd, dec_bcd;
    logic [31:0]         load_bin;
    logic                load_ok;
    logic [DIGITS-1:0]   blank;

    // Ripple carry/borrow: a digit changes only while every lower digit rolled over.
    always_comb begin
        logic       carry;
        logic       borrow;
        logic [3:0] d;
        inc_bcd = count_reg;
        dec_bcd = count_reg;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = count_reg[4*i +: 4];
            if (carry) begin
                inc_bcd[4*i +: 4] = (d == 4'd9) ? 4'd0 : d + 4'd1;
                carry             = (d == 4'd9);
            end
            if (borrow) begin
                dec_bcd[4*i +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
                borrow            = (d == 4'd0);
            end
        end
    end

    // Decode load_val to binary; non-BCD digits still produce a value but mark it invalid.
    always_comb begin
        logic       digits_ok;
        logic [3:0] d;
        load_bin  = '0;
        digits_ok = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = bus.load_val[4*i +: 4];
            if (d > 4'd9) begin
                digits_ok = 1'b0;
            end
            load_bin = load_bin * 32'd10 + {28'd0, d};
        end
        load_ok = digits_ok && (load_bin >= 32'(MIN_VAL)) && (load_bin <= 32'(MAX_VAL));
    end

    always_comb begin
        count_next    = count_reg;
        bin_next      = bin_reg;
        wrap_next     = 1'b0;
        load_err_next = 1'b0;
        if (bus.load) begin
            if (load_ok) begin
                count_next = bus.load_val;
                bin_next   = load_bin[BIN_W-1:0];
            end else begin
                load_err_next = 1'b1;
            end
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (bin_reg == MAX_BIN) begin
                    count_next = MIN_BCD;
                    bin_next   = MIN_BIN;
                    wrap_next  = 1'b1;
                end else begin
                    count_next = inc_bcd;
                    bin_next   = bin_reg + 1'b1;
                end
            end else begin
                if (bin_reg == MIN_BIN) begin
                    count_next = MAX_BCD;
                    bin_next   = MAX_BIN;
                    wrap_next  = 1'b1;
                end else begin
                    count_next = dec_bcd;
                    bin_next   = bin_reg - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg    <= RESET_BCD;
            bin_reg      <= RESET_BIN;
            wrap_reg     <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            bin_reg      <= bin_next;
            wrap_reg     <= wrap_next;
            load_err_reg <= load_err_next;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Scan from the top: a digit is blank while it and everything above it is zero.
    always_comb begin
        logic all_zero;
        blank    = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero = all_zero && (count_reg[4*i +: 4] == 4'd0);
            blank[i] = all_zero;
        end
    end
`else
    assign blank = '0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign bus.digits[8*gi +: 8] = blank[gi] ? 8'(BLANK_CODE)
                                                     : {4'd0, count_reg[4*gi +: 4]};
        end
    endgenerate

    assign bus.bin_value = bin_reg;
    assign bus.wrap      = wrap_reg;
    assign bus.load_err  = load_err_reg;

endmodule

// File: tb/tb_bcd_display_counter.sv
// Directed bench: default 2-digit counter plus a 3-digit 0..999 instance, expectations hand-computed.
module tb_bcd_display_counter;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] LZ = 8'd88;
`else
    localparam logic [7:0] LZ = 8'd0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   wrap_cnt;

    bcd_display_counter_if #(.DIGITS(2), .BIN_W(8))  a_if ();
    bcd_display_counter_if #(.DIGITS(3), .BIN_W(10)) b_if ();

    bcd_display_counter dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if.slave)
    );

    bcd_display_counter #(
        .DIGITS(3), .MIN_VAL(0), .MAX_VAL(999), .RESET_VAL(0), .BIN_W(10), .BLANK_CODE(88)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, observed, expected);
            $error("check %s observed %0h expected %0h", tag, observed, expected);
        end
        $display("check %s observed %0h expected %0h", tag, observed, expected);
    endtask

    initial begin
        a_if.en = 0; a_if.up_dn = 1; a_if.load = 0; a_if.load_val = '0;
        b_if.en = 0; b_if.up_dn = 1; b_if.load = 0; b_if.load_val = '0;

        // Reset state
        reset = 1; tick(); reset = 0;
        check("rst_digits", 32'(a_if.digits), {16'd0, LZ, 8'd1});
        check("rst_bin", 32'(a_if.bin_value), 32'd1);
        check("rst_wrap", 32'(a_if.wrap), 32'd0);
        check("rst_lerr", 32'(a_if.load_err), 32'd0);
        check("b_rst_digits", 32'(b_if.digits), {8'd0, LZ, LZ, 8'd0});
        check("b_rst_bin", 32'(b_if.bin_value), 32'd0);

        // Count up 98 steps to 99, then wrap to 1
        wrap_cnt = 0;
        a_if.en = 1; a_if.up_dn = 1;
        for (int i = 0; i < 98; i++) begin
            tick();
            wrap_cnt += int'(a_if.wrap);
        end
        check("up98_digits", 32'(a_if.digits), {16'd0, 8'd9, 8'd9});
        check("up98_bin", 32'(a_if.bin_value), 32'd99);
        tick(); wrap_cnt += int'(a_if.wrap);
        check("upwrap_digits", 32'(a_if.digits), {16'd0, LZ, 8'd1});
        check("upwrap_bin", 32'(a_if.bin_value), 32'd1);
        check("upwrap_pulse", 32'(a_if.wrap), 32'd1);
        a_if.en = 0; tick(); wrap_cnt += int'(a_if.wrap);
        check("upwrap_clear", 32'(a_if.wrap), 32'd0);
        check("wrap_once", 32'(wrap_cnt), 32'd1);

        // Load 09, up across the digit boundary and back down
        a_if.load = 1; a_if.load_val = 8'h09; tick(); a_if.load = 0;
        check("ld09_bin", 32'(a_if.bin_value), 32'd9);
        a_if.en = 1; a_if.up_dn = 1; tick(); a_if.en = 0;
        check("inc10_digits", 32'(a_if.digits), {16'd0, 8'd1, 8'd0});
        check("inc10_bin", 32'(a_if.bin_value), 32'd10);
        a_if.en = 1; a_if.up_dn = 0; tick(); a_if.en = 0;
        check("dec9_digits", 32'(a_if.digits), {16'd0, LZ, 8'd9});
        check("dec9_bin", 32'(a_if.bin_value), 32'd9);

        // Down from MIN wraps to MAX; rejected loads
        a_if.load = 1; a_if.load_val = 8'h01; tick(); a_if.load = 0;
        a_if.en = 1; a_if.up_dn = 0; tick(); a_if.en = 0;
        check("dnwrap_bin", 32'(a_if.bin_value), 32'd99);
        check("dnwrap_pulse", 32'(a_if.wrap), 32'd1);
        tick();
        check("dnwrap_clear", 32'(a_if.wrap), 32'd0);
        a_if.load = 1; a_if.load_val = 8'hA5; tick(); a_if.load = 0;
        check("ldA5_err", 32'(a_if.load_err), 32'd1);
        check("ldA5_bin", 32'(a_if.bin_value), 32'd99);
        check("ldA5_wrap", 32'(a_if.wrap), 32'd0);
        tick();
        check("ldA5_err_clear", 32'(a_if.load_err), 32'd0);
        a_if.load = 1; a_if.load_val = 8'h00; tick(); a_if.load = 0;
        check("ld00_err", 32'(a_if.load_err), 32'd1);
        check("ld00_digits", 32'(a_if.digits), {16'd0, 8'd9, 8'd9});

        // Load beats en; reset beats load and en
        a_if.load = 1; a_if.en = 1; a_if.up_dn = 1; a_if.load_val = 8'h42; tick();
        a_if.load = 0; a_if.en = 0;
        check("ld42_digits", 32'(a_if.digits), {16'd0, 8'd4, 8'd2});
        check("ld42_bin", 32'(a_if.bin_value), 32'd42);
        reset = 1; a_if.load = 1; a_if.en = 1; a_if.load_val = 8'hA5; tick();
        reset = 0; a_if.load = 0; a_if.en = 0;
        check("rstld_bin", 32'(a_if.bin_value), 32'd1);
        check("rstld_lerr", 32'(a_if.load_err), 32'd0);

        // Direction change between consecutive steps
        a_if.en = 1; a_if.up_dn = 1; tick(); tick(); tick();
        a_if.up_dn = 0; tick(); tick(); a_if.en = 0;
        check("updn_bin", 32'(a_if.bin_value), 32'd2);

        // Reset at MAX while stepping up: no wrap pulse
        a_if.load = 1; a_if.load_val = 8'h99; tick(); a_if.load = 0;
        reset = 1; a_if.en = 1; a_if.up_dn = 1; tick(); reset = 0; a_if.en = 0;
        check("rstmax_bin", 32'(a_if.bin_value), 32'd1);
        check("rstmax_wrap", 32'(a_if.wrap), 32'd0);

        // 3-digit instance: load 007, then wrap below 0
        b_if.load = 1; b_if.load_val = 12'h007; tick(); b_if.load = 0;
        check("b_ld007_digits", 32'(b_if.digits), {8'd0, LZ, LZ, 8'd7});
        check("b_ld007_bin", 32'(b_if.bin_value), 32'd7);
        b_if.load = 1; b_if.load_val = 12'h000; tick(); b_if.load = 0;
        b_if.en = 1; b_if.up_dn = 0; tick(); b_if.en = 0;
        check("b_dnwrap_digits", 32'(b_if.digits), {8'd0, 8'd9, 8'd9, 8'd9});
        check("b_dnwrap_bin", 32'(b_if.bin_value), 32'd999);
        check("b_dnwrap_pulse", 32'(b_if.wrap), 32'd1);
        b_if.load = 1; b_if.load_val = 12'h1A0; tick(); b_if.load = 0;
        check("b_ld1A0_err", 32'(b_if.load_err), 32'd1);
        check("b_ld1A0_bin", 32'(b_if.bin_value), 32'd999);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_display_counter.md
BCD_DISPLAY_COUNTER -- requirements
Module: bcd_display_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 2: number of BCD digits, legal 1..6.
REQ-002 SHALL have parameter MIN_VAL, default 1: lowest count value (decimal).
REQ-003 SHALL have parameter MAX_VAL, default 99: highest count value, MIN_VAL < MAX_VAL <= 10^DIGITS-1.
REQ-004 SHALL have parameter RESET_VAL, default 1: value after reset, MIN_VAL..MAX_VAL.
REQ-005 SHALL have parameter BIN_W, default 8: width of bin_value, >= clog2(MAX_VAL+1).
REQ-006 SHALL have parameter BLANK_CODE, default 88: digit code meaning blank, for the seven-seg decoder.
REQ-007 SHALL run on one clock; reset is synchronous and active-high.
REQ-008 clk  input  1  clock, all state on rising edge.
REQ-009 reset  input  1  synchronous active-high reset.
REQ-010 en  input  1  count tick; one step per cycle while high.
REQ-011 up_dn  input  1  1 = count up, 0 = count down; sampled only with en.
REQ-012 load  input  1  load request.
REQ-013 load_val  input  4*DIGITS  BCD load value, digit i in bits [4i+3:4i].
REQ-014 digits  output  8*DIGITS  per-digit code, digit i (i=0 least significant) in bits [8i+7:8i], value 0..9 or BLANK_CODE.
REQ-015 bin_value  output  BIN_W  binary equivalent of current count.
REQ-016 wrap  output  1  one-cycle pulse on wrap-around.
REQ-017 load_err  output  1  one-cycle pulse on rejected load.

Function
REQ-018 SHALL hold count as DIGITS BCD digits each 0..9, plus a parallel binary register always equal to the decimal count.
REQ-019 digits and bin_value SHALL be combinational from the state registers: new value visible the cycle after the triggering edge-sampled input (1-cycle latency).
REQ-020 Priority SHALL be reset > load > en; en ignored in a load cycle.
REQ-021 Up step: count < MAX_VAL -> count+1 with BCD carry ripple (9 -> 0, carry into next digit), same edge.
REQ-022 Up step at count == MAX_VAL -> count = MIN_VAL, wrap = 1 next cycle only.
REQ-023 Down step: count > MIN_VAL -> count-1 with BCD borrow (0 -> 9, borrow from next digit).
REQ-024 Down step at count == MIN_VAL -> count = MAX_VAL, wrap = 1.
REQ-025 Load with every load_val digit <= 9 and MIN_VAL <= load_val <= MAX_VAL -> count = load_val, bin_value = its binary value.
REQ-026 Load with any digit > 9 or value out of range -> count unchanged, load_err = 1 for one cycle, wrap = 0.
REQ-027 wrap and load_err SHALL be registered and low in every cycle not named above.
REQ-028 en held high for N cycles SHALL advance exactly N steps; up_dn change between steps takes effect on the next step.

Reset
REQ-029 On reset: count = RESET_VAL, bin_value = RESET_VAL, wrap = 0, load_err = 0; digits show RESET_VAL per REQ-031.
REQ-030 Reset asserted mid-count or together with load/en SHALL win; no wrap or load_err pulse issued.

Configuration
REQ-031 Macro LEADING_ZERO_BLANK_EN: when defined, each zero digit above the most significant non-zero digit outputs BLANK_CODE; digit 0 is never blanked (count 0 shows "0"); when undefined, all digits output their 0..9 value.

Verification
REQ-032 Defaults, LEADING_ZERO_BLANK_EN defined; reset -> digits {88,1}, bin_value 1, wrap 0.
REQ-033 Reset, en=1 up_dn=1 for 98 cycles -> count 99, digits {9,9}; one more -> count 1, digits {88,1}, wrap pulse exactly once.
REQ-034 Load 09 then one up step -> digits {1,0}, bin_value 10; one down step -> digits {88,9}, bin_value 9.
REQ-035 Count 1, en=1 up_dn=0 -> count 99, wrap = 1 one cycle; load_val 8'hA5 -> load_err pulse, count stays 99.
REQ-036 load=1 en=1 load_val 8'h42 same cycle -> count 42, no step; reset=1 with load=1 -> count 1, load_err 0.
REQ-037 Macro undefined, DIGITS=3 MIN_VAL=0 MAX_VAL=999, load 007 -> digits {0,0,7}, bin_value 7.
